// File: rtl/funrv32_pkg.sv
// Shared funRV32 constants and the regfile checker's state encoding.
package funrv32_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/regfile_checker_if.sv
// Two-port regfile read bus between the checker (master) and the register file.
interface regfile_checker_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic [AW-1:0] a1;
  logic [AW-1:0] a2;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;

  modport master (output a1, output a2, input r1, input r2);
  modport slave  (input a1, input a2, output r1, output r2);
endinterface

// File: rtl/regfile_chk_pipe.sv
// Valid/pair-index delay line matching the regfile read latency; depth 0 passes straight through.
module regfile_chk_pipe #(
  parameter int DEPTH = 1,
  parameter int KW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid_i,
  input  logic [KW-1:0] in_k_i,
  output logic          out_valid_o,
  output logic [KW-1:0] out_k_o
);

  if (DEPTH == 0) begin : g_wire
    assign out_valid_o = in_valid_i;
    assign out_k_o     = in_k_i;
  end else begin : g_regs
    logic [DEPTH-1:0] valid_q;
    logic [KW-1:0]    k_q [DEPTH];

    // Shift valid and index one stage per cycle; reset empties the pipe.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int i = 0; i < DEPTH; i++) k_q[i] <= '0;
      end else begin
        valid_q[0] <= in_valid_i;
        k_q[0]     <= in_k_i;
        for (int i = 1; i < DEPTH; i++) begin
          valid_q[i] <= valid_q[i-1];
          k_q[i]     <= k_q[i-1];
        end
      end
    end

    assign out_valid_o = valid_q[DEPTH-1];
    assign out_k_o     = k_q[DEPTH-1];
  end

endmodule

// File: rtl/regfile_checker.sv
// Sweeps every register two per cycle and checks each against base + index,
// reporting pass, error count and the lowest failing address.
module regfile_checker
  import funrv32_pkg::*;
#(
  parameter int AW      = REG_AW,
  parameter int DW      = XLEN,
  parameter int RD_LAT  = 1,
  parameter int ZERO_X0 = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DW-1:0]        base,
  regfile_checker_if.master    rf,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [AW:0]          err_count,
  output logic                 first_err_valid,
  output logic [AW-1:0]        first_err_addr
);

  localparam logic [AW-2:0] LAST_PAIR  = '1;
  localparam logic [1:0]    DRAIN_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  chk_state_e    state_q, state_d;
  logic [AW-2:0] k_q, k_d, k_inc_s;
  logic [AW-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [DW-1:0] base_q, base_d;
  logic [1:0]    drain_q, drain_d;
  logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [AW:0]   err_q, err_d;
  logic          fev_q, fev_d;
  logic [AW-1:0] fea_q, fea_d;

  logic          pv_s;
  logic [AW-2:0] pk_s;
  logic [DW-1:0] exp1_s, exp2_s;
  logic          mis1_s, mis2_s;

  regfile_chk_pipe #(.DEPTH(RD_LAT), .KW(AW-1)) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (state_q == ISSUE),
    .in_k_i      (k_q),
    .out_valid_o (pv_s),
    .out_k_o     (pk_s)
  );

  assign k_inc_s = k_q + 1'b1;
  assign exp1_s  = ((ZERO_X0 != 0) && (pk_s == '0)) ? '0 : base_q + DW'({pk_s, 1'b0});
  assign exp2_s  = base_q + DW'({pk_s, 1'b1});
  assign mis1_s  = pv_s && (rf.r1 != exp1_s);
  assign mis2_s  = pv_s && (rf.r2 != exp2_s);

  // Next-state, address issue and result accumulation.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a1_d    = '0;
    a2_d    = '0;
    base_d  = base_q;
    drain_d = drain_q;
    err_d   = err_q + {{AW{1'b0}}, mis1_s} + {{AW{1'b0}}, mis2_s};
    fev_d   = fev_q;
    fea_d   = fea_q;
    pass_d  = pass_q;

    if (!fev_q && (mis1_s || mis2_s)) begin
      fev_d = 1'b1;
      fea_d = mis1_s ? {pk_s, 1'b0} : {pk_s, 1'b1};
    end else begin
      fev_d = fev_q;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ISSUE;
          k_d     = '0;
          a1_d    = '0;
          a2_d    = AW'(1);
          base_d  = base;
          err_d   = '0;
          fev_d   = 1'b0;
          fea_d   = '0;
          pass_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ISSUE: begin
        if (k_q == LAST_PAIR) begin
          k_d     = '0;
          drain_d = DRAIN_LAST;
          state_d = (RD_LAT == 0) ? DONE : DRAIN;
        end else begin
          k_d  = k_inc_s;
          a1_d = {k_inc_s, 1'b0};
          a2_d = {k_inc_s, 1'b1};
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE) && (state_q != DONE);
    busy_d = (state_d == ISSUE) || (state_d == DRAIN);
    if (done_d) begin
      pass_d = (err_d == '0);
    end else begin
      pass_d = pass_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      base_q  <= '0;
      drain_q <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fea_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      base_q  <= base_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fea_q   <= fea_d;
    end
  end

  assign rf.a1           = a1_q;
  assign rf.a2           = a2_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_regfile_checker.sv
// Directed bench: a 1-cycle-latency regfile model read by two checker instances (x0 zero / x0 = base).
module tb_regfile_checker;
  import funrv32_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, start_nz = 1'b0;
  logic [31:0] base = 32'd0, base_nz = 32'd0;
  logic        busy, done, pass, fev;
  logic [5:0]  err;
  logic [4:0]  fea;
  logic        busy_nz, done_nz, pass_nz, fev_nz;
  logic [5:0]  err_nz;
  logic [4:0]  fea_nz;

  logic [31:0] regs [32];
  logic [4:0]  a1_log [41];
  logic [4:0]  a2_log [41];
  logic        busy_log [41];
  int checks = 0, passed = 0;

  regfile_checker_if #(.AW(5), .DW(32)) rf_if ();
  regfile_checker_if #(.AW(5), .DW(32)) rf_nz ();

  regfile_checker #(.AW(5), .DW(32), .RD_LAT(1), .ZERO_X0(1)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .rf(rf_if),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .first_err_valid(fev), .first_err_addr(fea)
  );

  regfile_checker #(.AW(5), .DW(32), .RD_LAT(1), .ZERO_X0(0)) dut_nz (
    .clk(clk), .reset(reset), .start(start_nz), .base(base_nz), .rf(rf_nz),
    .busy(busy_nz), .done(done_nz), .pass(pass_nz), .err_count(err_nz),
    .first_err_valid(fev_nz), .first_err_addr(fea_nz)
  );

  always #5 clk = ~clk;

  // Regfile model with one cycle of read latency on both ports.
  always @(posedge clk) begin
    rf_if.r1 <= regs[rf_if.a1];
    rf_if.r2 <= regs[rf_if.a2];
    rf_nz.r1 <= regs[rf_nz.a1];
    rf_nz.r2 <= regs[rf_nz.a2];
  end

  task automatic fill(input logic [31:0] b, input bit x0_zero);
    for (int i = 0; i < 32; i++) regs[i] = b + 32'(i);
    if (x0_zero) regs[0] = 32'd0;
  endtask

  // Start in cycle T, optionally pulse start again in cycle T+extra, observe T+1..T+40.
  task automatic run_sweep(input logic [31:0] b, input int extra,
                           output int first_cyc, output int last_cyc, output int n_done);
    @(negedge clk);
    base = b;
    start = 1'b1;
    @(negedge clk);
    first_cyc = 0; last_cyc = 0; n_done = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == extra);
      a1_log[c] = rf_if.a1;
      a2_log[c] = rf_if.a2;
      busy_log[c] = busy;
      if (done) begin
        n_done++;
        last_cyc = c;
        if (first_cyc == 0) first_cyc = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rf_if.a1 !== 5'd0) $display("FAIL reset_a1: got %0d want 0", rf_if.a1); else passed++;
    checks++; if (rf_if.a2 !== 5'd0) $display("FAIL reset_a2: got %0d want 0", rf_if.a2); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL reset_pass: got %b want 0", pass); else passed++;
    checks++; if (err !== 6'd0) $display("FAIL reset_err: got %0d want 0", err); else passed++;
    checks++; if (fev !== 1'b0 || fea !== 5'd0) $display("FAIL reset_first: got %b/%0d want 0/0", fev, fea); else passed++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean;
    int f, l, n;
    fill(32'd0, 1'b1);
    run_sweep(32'd0, 0, f, l, n);
    checks++; if (f !== 18 || n !== 1) $display("FAIL clean_done: got cyc %0d count %0d want 18/1", f, n); else passed++;
    checks++; if (a1_log[1] !== 5'd0 || a2_log[1] !== 5'd1) $display("FAIL clean_first_pair: got %0d/%0d want 0/1", a1_log[1], a2_log[1]); else passed++;
    checks++; if (a1_log[16] !== 5'd30 || a2_log[16] !== 5'd31) $display("FAIL clean_last_pair: got %0d/%0d want 30/31", a1_log[16], a2_log[16]); else passed++;
    checks++; if (a1_log[17] !== 5'd0 || a2_log[17] !== 5'd0) $display("FAIL clean_addr_idle: got %0d/%0d want 0/0", a1_log[17], a2_log[17]); else passed++;
    checks++; if (busy_log[1] !== 1'b1 || busy_log[17] !== 1'b1 || busy_log[18] !== 1'b0) $display("FAIL clean_busy: got %b%b%b want 110", busy_log[1], busy_log[17], busy_log[18]); else passed++;
    checks++; if (pass !== 1'b1 || err !== 6'd0 || fev !== 1'b0) $display("FAIL clean_result: got pass %b err %0d fev %b want 1/0/0", pass, err, fev); else passed++;
  endtask

  task automatic test_base5;
    int f, l, n;
    fill(32'd0, 1'b1);
    run_sweep(32'd5, 0, f, l, n);
    checks++; if (err !== 6'd31) $display("FAIL base5_err: got %0d want 31", err); else passed++;
    checks++; if (fev !== 1'b1 || fea !== 5'd1) $display("FAIL base5_first: got %b/%0d want 1/1", fev, fea); else passed++;
    checks++; if (pass !== 1'b0 || f !== 18) $display("FAIL base5_pass: got pass %b cyc %0d want 0/18", pass, f); else passed++;
  endtask

  task automatic test_single_corrupt;
    int f, l, n;
    fill(32'd0, 1'b1);
    regs[17] = 32'hDEAD_BEEF;
    run_sweep(32'd0, 0, f, l, n);
    checks++; if (err !== 6'd1) $display("FAIL r17_err: got %0d want 1", err); else passed++;
    checks++; if (fev !== 1'b1 || fea !== 5'd17) $display("FAIL r17_first: got %b/%0d want 1/17", fev, fea); else passed++;
    checks++; if (pass !== 1'b0) $display("FAIL r17_pass: got %b want 0", pass); else passed++;
  endtask

  task automatic test_pair_corrupt;
    int f, l, n;
    fill(32'd0, 1'b1);
    regs[4] = 32'h0000_1234;
    regs[5] = 32'h0000_5678;
    run_sweep(32'd0, 0, f, l, n);
    checks++; if (err !== 6'd2) $display("FAIL pair_err: got %0d want 2", err); else passed++;
    checks++; if (fea !== 5'd4) $display("FAIL pair_first: got %0d want 4", fea); else passed++;
  endtask

  task automatic test_back_to_back;
    int f, l, n;
    fill(32'd0, 1'b1);
    run_sweep(32'd0, 5, f, l, n);
    checks++; if (n !== 1 || f !== 18) $display("FAIL ignored_start: got count %0d cyc %0d want 1/18", n, f); else passed++;
    run_sweep(32'd0, 18, f, l, n);
    checks++; if (n !== 2 || f !== 18 || l !== 36) $display("FAIL done_cycle_start: got count %0d cyc %0d/%0d want 2 at 18/36", n, f, l); else passed++;
    checks++; if (pass !== 1'b1) $display("FAIL done_cycle_pass: got %b want 1", pass); else passed++;
  endtask

  task automatic test_reset_abort;
    int f, l, n;
    fill(32'd0, 1'b1);
    regs[3] = 32'd99;
    @(negedge clk);
    base = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    for (int c = 1; c <= 30; c++) begin
      reset = (c == 8);
      if (c == 9) begin
        checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        checks++; if (rf_if.a1 !== 5'd0 || rf_if.a2 !== 5'd0) $display("FAIL abort_addr: got %0d/%0d want 0/0", rf_if.a1, rf_if.a2); else passed++;
        checks++; if (err !== 6'd0 || fev !== 1'b0) $display("FAIL abort_result: got err %0d fev %b want 0/0", err, fev); else passed++;
      end
      if (done) n++;
      @(negedge clk);
    end
    reset = 1'b0;
    checks++; if (n !== 0) $display("FAIL abort_no_done: got %0d dones want 0", n); else passed++;
    regs[3] = 32'd3;
    run_sweep(32'd0, 0, f, l, n);
    checks++; if (pass !== 1'b1 || f !== 18) $display("FAIL abort_restart: got pass %b cyc %0d want 1/18", pass, f); else passed++;
  endtask

  task automatic test_wrap;
    int f, n;
    fill(32'hFFFF_FFF0, 1'b0);
    checks++; if (regs[31] !== 32'h0000_000F) $display("FAIL wrap_fill: got %h want 0000000f", regs[31]); else passed++;
    @(negedge clk);
    base_nz = 32'hFFFF_FFF0;
    start_nz = 1'b1;
    @(negedge clk);
    start_nz = 1'b0;
    f = 0; n = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done_nz) begin
        n++;
        if (f == 0) f = c;
      end
      @(negedge clk);
    end
    checks++; if (n !== 1 || f !== 18) $display("FAIL wrap_done: got count %0d cyc %0d want 1/18", n, f); else passed++;
    checks++; if (pass_nz !== 1'b1 || err_nz !== 6'd0 || fev_nz !== 1'b0) $display("FAIL wrap_result: got pass %b err %0d fev %b want 1/0/0", pass_nz, err_nz, fev_nz); else passed++;
  endtask

  initial begin
    fill(32'd0, 1'b1);
    test_reset();
    test_clean();
    test_base5();
    test_single_corrupt();
    test_pair_corrupt();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
